// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Performs LDW/STW word accesses on the CPU
// bus with a req/rdy handshake, flags misaligned addresses and loads the
// MEM/WB pipeline register.
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort a bus access that has
// waited TIMEOUT_CYC cycles for bus_rdy (reported as exception code 7).
module mem_stage #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    output logic        bus_req,
    output logic [29:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy,
    output logic        mem_busy,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    localparam logic [1:0] OP_LDW = 2'd1;
    localparam logic [1:0] OP_STW = 2'd2;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;
    localparam logic [2:0] EXP_BUS_ERR    = 3'd7;

    // Reject a counter too narrow to ever reach the timeout limit.
    generate
        if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_bad_cfg
            $error("mem_stage: CNT_W too narrow for TIMEOUT_CYC");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic        kill_reg;
    logic [31:0] rbuf_reg;
    logic        is_mem, acc, mis;
    logic        timeout;   // BUS gave up waiting this cycle
    logic        bus_err;   // MEM/WB should record a bus error
    logic [31:0] load_data;

    assign is_mem = ex_en && (ex_exp_code == 3'd0) &&
                    ((ex_mem_op == OP_LDW) || (ex_mem_op == OP_STW));
    assign acc    = is_mem && (ex_out[1:0] == 2'b00) && !flush;
    assign mis    = is_mem && (ex_out[1:0] != 2'b00);

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;  // timeout happened while stalled; report on release

    assign timeout = (state_reg == S_BUS) && !bus_rdy && (cnt_reg == CNT_LIMIT);
    assign bus_err = timeout || ((state_reg == S_DONE) && err_reg);

    // Count BUS cycles without bus_rdy, restarting on each new access.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (state_reg == S_IDLE && state_next == S_BUS) begin
            cnt_reg <= '0;
        end else if (state_reg == S_BUS && !bus_rdy && !timeout) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Remember a timeout that ended in DONE so the error reaches MEM/WB later.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (timeout && stall) begin
            err_reg <= 1'b1;
        end else if (state_reg == S_DONE && !stall) begin
            err_reg <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: a started access always runs to completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (acc) state_next = S_BUS;
            S_BUS:  if (bus_rdy || timeout) state_next = stall ? S_DONE : S_IDLE;
            S_DONE: if (!stall) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: bus drive and stall request.
    always_comb begin
        bus_req     = 1'b0;
        bus_addr    = '0;
        bus_we      = 1'b0;
        bus_wr_data = '0;
        mem_busy    = 1'b0;
        case (state_reg)
            S_IDLE: mem_busy = acc;
            S_BUS: begin
                bus_req     = !timeout;
                bus_addr    = ex_out[31:2];
                bus_we      = (ex_mem_op == OP_STW);
                bus_wr_data = ex_mem_wr_data;
                mem_busy    = !bus_rdy && !timeout;
            end
            default: ;
        endcase
    end

    // Capture load data that arrives while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rbuf_reg <= '0;
        end else if (state_reg == S_BUS && bus_rdy && stall) begin
            rbuf_reg <= bus_rd_data;
        end
    end

    // A flush during an access turns the eventual MEM/WB load into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            kill_reg <= 1'b0;
        end else if (!stall) begin
            kill_reg <= 1'b0;
        end else if (flush && state_reg != S_IDLE) begin
            kill_reg <= 1'b1;
        end
    end

    // Select load data from the live bus or the stall buffer.
    always_comb begin
        load_data = ex_out;
        if (ex_mem_op == OP_LDW) begin
            if (state_reg == S_BUS) begin
                load_data = bus_rd_data;
            end else if (state_reg == S_DONE) begin
                load_data = rbuf_reg;
            end
        end
    end

    // MEM/WB pipeline register; holds while stalled.
    always_ff @(posedge clk) begin
        if (reset || (!stall && (flush || kill_reg))) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= '0;
            mem_out      <= '0;
        end else if (!stall) begin
            mem_pc      <= ex_pc;
            mem_en      <= ex_en;
            mem_br_flag <= ex_br_flag;
            if (bus_err || mis) begin
                mem_ctrl_op  <= '0;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= bus_err ? EXP_BUS_ERR : EXP_MISS_ALIGN;
                mem_out      <= '0;
            end else begin
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= ex_gpr_we_;
                mem_exp_code <= ex_exp_code;
                mem_out      <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table-driven bench for mem_stage plus hand-written
// sequences for stall-after-rdy, flush during access, reset mid-access and
// (with MEM_BUS_TIMEOUT_EN) the bus timeout.
module tb_mem_stage;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, flush, ext_stall;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out, bus_rd_data, bus_wr_data, mem_out;
    logic [4:0]  ex_dst_addr, mem_dst_addr;
    logic [2:0]  ex_exp_code, mem_exp_code;
    logic        bus_req, bus_we, bus_rdy, mem_busy;
    logic [29:0] bus_addr, mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Controller model: stall includes the stage's own busy request.
    assign stall = mem_busy | ext_stall;

    mem_stage #(.TIMEOUT_CYC(TO_CYC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
        .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy),
        .mem_busy(mem_busy), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_at;
        logic [2:0]  exp_in;
        logic        we_in;
        int          e_req;
        int          e_busy;
        logic [29:0] e_baddr;
        logic        e_bwe;
        logic [31:0] e_out;
        logic [2:0]  e_exp;
        logic        e_we_;
    } vec_t;

    vec_t vecs[9];

    task automatic set_ex(input logic en, input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] exc, input logic we_);
        ex_en = en; ex_mem_op = op; ex_out = addr; ex_mem_wr_data = wdata;
        ex_exp_code = exc; ex_gpr_we_ = we_;
        ex_pc = addr[31:2] ^ 30'h155; ex_br_flag = addr[2]; ex_ctrl_op = 2'd1;
        ex_dst_addr = 5'd9;
    endtask

    // Apply one vector (called just after a rising edge) and run it to completion.
    task automatic run_vec(input int idx, input vec_t v);
        int  req_c = 0;
        int  busy_c = 0;
        bit  done = 0;
        set_ex(v.en, v.op, v.addr, v.wdata, v.exp_in, v.we_in);
        bus_rd_data = v.rdata;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            bus_rdy = bus_req && (req_c == v.rdy_at);
            #1;
            if (bus_req) begin
                if (req_c == 0) begin
                    check($sformatf("v%0d bus_addr", idx), {2'b0, bus_addr}, {2'b0, v.e_baddr});
                    check($sformatf("v%0d bus_we", idx), {31'b0, bus_we}, {31'b0, v.e_bwe});
                    if (v.e_bwe)
                        check($sformatf("v%0d bus_wr_data", idx), bus_wr_data, v.wdata);
                end
                req_c++;
            end
            if (mem_busy) busy_c++;
            else done = 1;
            @(posedge clk); #1;
            bus_rdy = 1'b0;
        end
        if (!done) check($sformatf("v%0d completion", idx), 32'd0, 32'd1);
        check($sformatf("v%0d req_cycles", idx), req_c, v.e_req);
        check($sformatf("v%0d busy_cycles", idx), busy_c, v.e_busy);
        check($sformatf("v%0d mem_out", idx), mem_out, v.e_out);
        check($sformatf("v%0d mem_exp_code", idx), {29'b0, mem_exp_code}, {29'b0, v.e_exp});
        check($sformatf("v%0d mem_gpr_we_", idx), {31'b0, mem_gpr_we_}, {31'b0, v.e_we_});
        check($sformatf("v%0d mem_en", idx), {31'b0, mem_en}, {31'b0, v.en});
        check($sformatf("v%0d mem_pc", idx), {2'b0, mem_pc}, {2'b0, v.addr[31:2] ^ 30'h155});
        $display("vec %0d op=%0d addr=0x%08h req=%0d busy=%0d mem_out=0x%08h exp=%0d",
                 idx, v.op, v.addr, req_c, busy_c, mem_out, mem_exp_code);
    endtask

    initial begin
        int req_c;
        int cyc;
        //          en op  addr          wdata         rdata         rdy exp we | req busy baddr         bwe out           exp we_
        vecs[0] = '{1, 1, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 0, 0,   2, 2, 30'h40,        0, 32'hDEAD_BEEF, 0, 0};
        vecs[1] = '{1, 2, 32'h0000_0204, 32'h1234_5678, 32'h0,        0, 0, 1,   1, 1, 30'h81,        1, 32'h0000_0204, 0, 1};
        vecs[2] = '{1, 1, 32'h0000_0102, 32'h0,        32'h0,         0, 0, 0,   0, 0, 30'h0,         0, 32'h0,         4, 1};
        vecs[3] = '{1, 0, 32'h0000_0055, 32'h0,        32'h0,         0, 0, 0,   0, 0, 30'h0,         0, 32'h0000_0055, 0, 0};
        vecs[4] = '{1, 3, 32'h0000_0103, 32'h0,        32'h0,         0, 0, 0,   0, 0, 30'h0,         0, 32'h0000_0103, 0, 0};
        vecs[5] = '{1, 1, 32'h0000_0200, 32'h0,        32'h0,         0, 2, 0,   0, 0, 30'h0,         0, 32'h0000_0200, 2, 0};
        vecs[6] = '{0, 1, 32'h0000_0300, 32'h0,        32'h0,         0, 0, 0,   0, 0, 30'h0,         0, 32'h0000_0300, 0, 0};
        vecs[7] = '{1, 2, 32'h0000_0003, 32'h0,        32'h0,         0, 0, 1,   0, 0, 30'h0,         0, 32'h0,         4, 1};
        vecs[8] = '{1, 1, 32'hFFFF_FFFC, 32'h0,        32'hA5A5_5A5A, 3, 0, 0,   4, 4, 30'h3FFF_FFFF, 0, 32'hA5A5_5A5A, 0, 0};

        reset = 1'b1; flush = 1'b0; ext_stall = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
        set_ex(0, 0, 32'h0, 32'h0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst bus_req", {31'b0, bus_req}, 32'd0);
        check("rst bus_addr", {2'b0, bus_addr}, 32'd0);
        check("rst mem_gpr_we_", {31'b0, mem_gpr_we_}, 32'd1);
        check("rst mem_en", {31'b0, mem_en}, 32'd0);
        check("rst mem_out", mem_out, 32'd0);
        check("rst mem_exp_code", {29'b0, mem_exp_code}, 32'd0);
        $display("reset: bus_req=%0d mem_gpr_we_=%0d mem_out=0x%08h", bus_req, mem_gpr_we_, mem_out);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Load completes while externally stalled: buffered data, single request.
        set_ex(1, 1, 32'h0000_0400, 32'h0, 3'd0, 1'b0);
        ext_stall = 1'b1; bus_rd_data = 32'hCAFE_F00D; req_c = 0;
        @(negedge clk); if (bus_req) req_c++;
        @(posedge clk); #1;
        @(negedge clk); if (bus_req) req_c++; bus_rdy = 1'b1;
        @(posedge clk); #1;
        bus_rdy = 1'b0; bus_rd_data = 32'h0BAD_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); if (bus_req) req_c++;
            check("done mem_out held", mem_out, 32'hA5A5_5A5A);
            @(posedge clk); #1;
        end
        ext_stall = 1'b0;
        @(negedge clk); if (bus_req) req_c++;
        check("done busy", {31'b0, mem_busy}, 32'd0);
        @(posedge clk); #1;
        ex_en = 1'b0;
        check("done req_cycles", req_c, 32'd1);
        check("done mem_out", mem_out, 32'hCAFE_F00D);
        check("done mem_en", {31'b0, mem_en}, 32'd1);
        $display("stall-after-rdy: req=%0d mem_out=0x%08h", req_c, mem_out);
        @(posedge clk); #1;

        // Flush in first BUS cycle, rdy in third: access completes, then bubble.
        set_ex(1, 1, 32'h0000_0500, 32'h0, 3'd0, 1'b0);
        bus_rd_data = 32'h1111_2222; req_c = 0;
        @(posedge clk); #1;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); if (bus_req) req_c++; bus_rdy = (i == 2);
            @(posedge clk); #1;
            flush = 1'b0; bus_rdy = 1'b0;
        end
        ex_en = 1'b0;
        check("flush req_cycles", req_c, 32'd3);
        check("flush mem_en", {31'b0, mem_en}, 32'd0);
        check("flush mem_gpr_we_", {31'b0, mem_gpr_we_}, 32'd1);
        check("flush mem_out", mem_out, 32'd0);
        $display("flush-in-bus: req=%0d mem_en=%0d mem_gpr_we_=%0d", req_c, mem_en, mem_gpr_we_);

        // Load a non-zero MEM/WB value, then reset in the middle of an access.
        set_ex(1, 0, 32'h0000_0777, 32'h0, 3'd0, 1'b0);
        @(posedge clk); #1;
        set_ex(1, 1, 32'h0000_0600, 32'h0, 3'd0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre-reset bus_req", {31'b0, bus_req}, 32'd1);
        check("pre-reset mem_out", mem_out, 32'h0000_0777);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst bus_req", {31'b0, bus_req}, 32'd0);
        check("midrst mem_out", mem_out, 32'd0);
        check("midrst mem_en", {31'b0, mem_en}, 32'd0);
        check("midrst mem_gpr_we_", {31'b0, mem_gpr_we_}, 32'd1);
        $display("reset-mid-access: bus_req=%0d mem_out=0x%08h", bus_req, mem_out);
        ex_en = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

`ifdef MEM_BUS_TIMEOUT_EN
        // No rdy ever: request drops after TO_CYC BUS cycles, bus error recorded.
        set_ex(1, 1, 32'h0000_0800, 32'h0, 3'd0, 1'b0);
        req_c = 0; cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (bus_req) req_c++;
            cyc++;
            if (!mem_busy) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ex_en = 1'b0;
        check("timeout bounded", {31'b0, cyc < 40}, 32'd1);
        check("timeout req_cycles", req_c, TO_CYC);
        check("timeout mem_exp_code", {29'b0, mem_exp_code}, 32'd7);
        check("timeout mem_gpr_we_", {31'b0, mem_gpr_we_}, 32'd1);
        check("timeout mem_out", mem_out, 32'd0);
        $display("timeout: req=%0d exp=%0d", req_c, mem_exp_code);
`else
        cyc = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
